// File: rtl/mem_pkg.sv
// Shared types for the memory-access pipeline stage.
// Access sizes, FSM states and lane offset width.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mem_state_t;

    localparam int OFF_W = 3;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory-access stage.
// Store enables/shift, misalignment check, load extract/extend.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [OFF_W-1:0] st_off,
    input  mem_size_t        st_size,
    input  logic [DW-1:0]    st_data,
    output logic [DW/8-1:0]  st_byte_en,
    output logic [DW-1:0]    st_lane_data,
    output logic             st_misaligned,
    input  logic [OFF_W-1:0] ld_off,
    input  mem_size_t        ld_size,
    input  logic             ld_unsigned,
    input  logic [DW-1:0]    ld_bus_data,
    output logic [DW-1:0]    ld_data
);

    localparam int BE_W = DW / 8;

    logic [BE_W-1:0] be_base;
    logic [DW-1:0]   ld_shift;

    // Store side: lane enables, lane data and natural-alignment check
    always_comb begin
        be_base       = '0;
        st_misaligned = 1'b0;
        unique case (st_size)
            BYTE: begin
                be_base = BE_W'(8'h01);
            end
            HALF: begin
                be_base       = BE_W'(8'h03);
                st_misaligned = st_off[0];
            end
            WORD: begin
                be_base       = BE_W'(8'h0F);
                st_misaligned = |st_off[1:0];
            end
            DOUBLE: begin
                be_base       = '1;
                st_misaligned = |st_off;
            end
        endcase
        if (st_size == DOUBLE) begin
            st_byte_en = '1;
        end else begin
            st_byte_en = be_base << st_off;
        end
        st_lane_data = st_data << {st_off, 3'b000};
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        ld_shift = ld_bus_data >> {ld_off, 3'b000};
        ld_data  = ld_shift;
        unique case (ld_size)
            BYTE: begin
                ld_data = ld_unsigned
                    ? {{(DW-8){1'b0}}, ld_shift[7:0]}
                    : {{(DW-8){ld_shift[7]}}, ld_shift[7:0]};
            end
            HALF: begin
                ld_data = ld_unsigned
                    ? {{(DW-16){1'b0}}, ld_shift[15:0]}
                    : {{(DW-16){ld_shift[15]}}, ld_shift[15:0]};
            end
            WORD: begin
                ld_data = ld_unsigned
                    ? {{(DW-32){1'b0}}, ld_shift[31:0]}
                    : {{(DW-32){ld_shift[31]}}, ld_shift[31:0]};
            end
            DOUBLE: begin
                ld_data = ld_shift;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage between execute and writeback.
// Single-beat bus load/store with stall while a transaction is open.
module memory_access
    import mem_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_ADDR_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inValid,
    input  logic                        inMemRead,
    input  logic                        inMemWrite,
    input  logic [1:0]                  inMemSize,
    input  logic                        inMemUnsigned,
    input  logic [BUS_ADDR_WIDTH-1:0]   inAddress,
    input  logic [BUS_DATA_WIDTH-1:0]   inWriteData,
    input  logic [BUS_DATA_WIDTH-1:0]   inALUData,
    input  logic                        inMemOrReg,
    output logic                        outStall,
    output logic                        outValid,
    output logic                        outFault,
    output logic [BUS_DATA_WIDTH-1:0]   outReadData,
    output logic [BUS_DATA_WIDTH-1:0]   outALUData,
    output logic                        outMemOrReg,
    output logic                        outBusReq,
    output logic                        outBusWrite,
    output logic [BUS_ADDR_WIDTH-1:0]   outBusAddr,
    output logic [BUS_DATA_WIDTH-1:0]   outBusWriteData,
    output logic [BUS_DATA_WIDTH/8-1:0] outBusByteEn,
    input  logic                        inBusGrant,
    input  logic                        inBusRespValid,
    input  logic [BUS_DATA_WIDTH-1:0]   inBusRespData,
    output logic                        outBusRespAck
);

    localparam int DW   = BUS_DATA_WIDTH;
    localparam int AW   = BUS_ADDR_WIDTH;
    localparam int BE_W = DW / 8;

    mem_state_t       state_q, state_d;
    mem_size_t        size_q, size_d;
    logic             uns_q, uns_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [DW-1:0]    alu_q, alu_d;
    logic             mor_q, mor_d;
    logic             req_q, req_d;
    logic             bwr_q, bwr_d;
    logic [AW-1:0]    baddr_q, baddr_d;
    logic [DW-1:0]    bwdata_q, bwdata_d;
    logic [BE_W-1:0]  bbe_q, bbe_d;

    logic [BE_W-1:0]  st_be;
    logic [DW-1:0]    st_lane;
    logic             st_misal;
    logic [DW-1:0]    ld_ext;
    logic             is_mem;
    logic             is_store;

    mem_lane_align #(
        .DW (DW)
    ) u_align (
        .st_off        (inAddress[OFF_W-1:0]),
        .st_size       (mem_size_t'(inMemSize)),
        .st_data       (inWriteData),
        .st_byte_en    (st_be),
        .st_lane_data  (st_lane),
        .st_misaligned (st_misal),
        .ld_off        (off_q),
        .ld_size       (size_q),
        .ld_unsigned   (uns_q),
        .ld_bus_data   (inBusRespData),
        .ld_data       (ld_ext)
    );

    assign is_mem   = inMemRead | inMemWrite;
    assign is_store = inMemWrite & ~inMemRead;

    assign outStall      = (state_q == REQ) || (state_q == WAIT);
    assign outBusRespAck = (state_q == WAIT) && inBusRespValid;

    assign outValid        = valid_q;
    assign outFault        = fault_q;
    assign outReadData     = rdata_q;
    assign outALUData      = alu_q;
    assign outMemOrReg     = mor_q;
    assign outBusReq       = req_q;
    assign outBusWrite     = bwr_q;
    assign outBusAddr      = baddr_q;
    assign outBusWriteData = bwdata_q;
    assign outBusByteEn    = bbe_q;

    // Next-state and next-output decode for the stage FSM
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        fault_d  = 1'b0;
        rdata_d  = rdata_q;
        alu_d    = alu_q;
        mor_d    = mor_q;
        req_d    = 1'b0;
        bwr_d    = bwr_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;
        bbe_d    = bbe_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (inValid) begin
                    alu_d   = inALUData;
                    mor_d   = inMemOrReg;
                    rdata_d = '0;
                    if (!is_mem) begin
                        state_d = DONE;
                    end else if (st_misal) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d  = REQ;
                        req_d    = 1'b1;
                        size_d   = mem_size_t'(inMemSize);
                        uns_d    = inMemUnsigned;
                        off_d    = inAddress[OFF_W-1:0];
                        bwr_d    = is_store;
                        baddr_d  = {inAddress[AW-1:OFF_W], {OFF_W{1'b0}}};
                        bwdata_d = is_store ? st_lane : '0;
                        bbe_d    = st_be;
                    end
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (inBusGrant) begin
                    req_d   = 1'b0;
                    state_d = bwr_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (inBusRespValid) begin
                    rdata_d = ld_ext;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == DONE);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            size_q   <= BYTE;
            uns_q    <= 1'b0;
            off_q    <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
            alu_q    <= '0;
            mor_q    <= 1'b0;
            req_q    <= 1'b0;
            bwr_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            bbe_q    <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
            alu_q    <= alu_d;
            mor_q    <= mor_d;
            req_q    <= req_d;
            bwr_q    <= bwr_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            bbe_q    <= bbe_d;
        end
    end

endmodule
